// File: rtl/nibble_arb_pkg.sv
// Shared constants and state encoding for the nibble count arbiter.
// Optional runtime match register is enabled with MATCH_CFG_EN.
package nibble_arb_pkg;

  localparam int DATA_W  = 16;
  localparam int RES_W   = 3;
  localparam int NIBBLES = 4;

  localparam logic [3:0] MATCH_DEFAULT = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_match_count.sv
// Counts the nibbles of one word equal to a match value (0..NIBBLES).
// Purely combinational.
module nibble_match_count
  import nibble_arb_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [3:0]        match,
  output logic [RES_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      count = count + RES_W'(word[4*n +: 4] == match);
    end
  end

endmodule

// File: rtl/nibble_count_arbiter.sv
// Round-robin shared nibble-count unit with valid/ready result port.
// Define MATCH_CFG_EN for a writable match register (i_cfg_we/i_cfg_nibble).
module nibble_count_arbiter
  import nibble_arb_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter int         ID_W         = $clog2(N_REQ),
  parameter logic [3:0] MATCH_NIBBLE = MATCH_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [DATA_W*N_REQ-1:0] i_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_valid,
  input  logic                    i_rdy,
  output logic [ID_W-1:0]         o_id,
  output logic [RES_W-1:0]        o_data
`ifdef MATCH_CFG_EN
  ,
  input  logic                    i_cfg_we,
  input  logic [3:0]              i_cfg_nibble
`endif
);

  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    cur_id;
  logic [DATA_W-1:0]  operand;
  logic [3:0]         match;
  logic [RES_W-1:0]   count;

  logic               found;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    nxt;
  logic [ID_W-1:0]    idx;

`ifdef MATCH_CFG_EN
  logic [3:0] match_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      match_q <= MATCH_NIBBLE;
    end else if (i_cfg_we) begin
      match_q <= i_cfg_nibble;
    end
  end

  assign match = match_q;
`else
  assign match = MATCH_NIBBLE;
`endif

  // Walk from ptr upward, wrapping at N_REQ so ids >= N_REQ never appear
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  assign nxt = (win == LAST) ? '0 : win + 1'b1;

  nibble_match_count u_count (
    .word  (operand),
    .match (match),
    .count (count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_gnt   <= '0;
      o_valid <= 1'b0;
      o_id    <= '0;
      o_data  <= '0;
      operand <= '0;
      cur_id  <= '0;
      ptr     <= '0;
    end else begin
      o_gnt <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            o_gnt   <= N_REQ'(1) << win;
            operand <= i_data[win*DATA_W +: DATA_W];
            cur_id  <= win;
            ptr     <= nxt;
            state   <= EXEC;
          end
        end
        EXEC: begin
          o_data  <= count;
          o_id    <= cur_id;
          o_valid <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          if (i_rdy) begin
            o_valid <= 1'b0;
            if (found) begin
              o_gnt   <= N_REQ'(1) << win;
              operand <= i_data[win*DATA_W +: DATA_W];
              cur_id  <= win;
              ptr     <= nxt;
              state   <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_count_arbiter.sv
// Directed and randomized checks of nibble_count_arbiter (N_REQ=4, match B).
// MATCH_CFG_EN adds the match-register scenario.
module tb_nibble_count_arbiter;

  localparam int N = 4;

  typedef struct {
    int id;
    int res;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [16*N-1:0] data;
  logic          valid;
  logic [1:0]    id;
  logic [2:0]    res;
`ifdef MATCH_CFG_EN
  logic          cfg_we;
  logic [3:0]    cfg_nib;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_count_arbiter #(
    .N_REQ        (4),
    .ID_W         (2),
    .MATCH_NIBBLE (4'hB)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_data  (data),
    .o_gnt   (gnt),
    .o_valid (valid),
    .i_rdy   (rdy),
    .o_id    (id),
    .o_data  (res)
`ifdef MATCH_CFG_EN
    ,
    .i_cfg_we     (cfg_we),
    .i_cfg_nibble (cfg_nib)
`endif
  );

  function automatic int ref_count(logic [15:0] w, logic [3:0] m);
    int c = 0;
    for (int n = 0; n < 4; n++)
      if (w[4*n +: 4] == m) c++;
    return c;
  endfunction

  function automatic int ref_winner(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(int k, logic [15:0] w);
    data[16*k +: 16] = w;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    rdy = 1'b1;
`ifdef MATCH_CFG_EN
    cfg_we  = 1'b0;
    cfg_nib = 4'h0;
`endif
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_gnt(string tag);
    int n = 0;
    while (gnt == '0 && n < 10) begin
      tick;
      n++;
    end
    check({tag, "_gnt_seen"}, 32'(gnt != '0), 1);
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!valid && n < 10) begin
      tick;
      n++;
    end
    check({tag, "_valid_seen"}, 32'(valid), 1);
  endtask

  task automatic serve(string tag, int k, int exp_res);
    wait_gnt(tag);
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
    tick;
    req[k] = 1'b0;
    check({tag, "_pulse"}, 32'(gnt), 0);
    wait_valid(tag);
    check({tag, "_id"}, 32'(id), k);
    check({tag, "_data"}, 32'(res), exp_res);
  endtask

  initial begin
    exp_t          expq[$];
    exp_t          e;
    logic [N-1:0]  req_pre;
    logic [16*N-1:0] data_pre;
    logic          rdy_pre;
    logic          valid_pre;
    logic [1:0]    id_pre;
    logic [2:0]    res_pre;
    logic [15:0]   w;
    int            rr;
    int            drop;
    int            win;

    data = '0;
    do_reset;

    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_id", 32'(id), 0);
    check("rst_data", 32'(res), 0);

    set_word(0, 16'hbbb0);
    req = 4'b0001;
    serve("t1", 0, 3);
    tick;
    check("t1_accept", 32'(valid), 0);

    do_reset;
    set_word(0, 16'hbbbb);
    set_word(1, 16'h3422);
    set_word(2, 16'h0b0b);
    set_word(3, 16'hb000);
    req = 4'b1111;
    serve("t2_0", 0, 4);
    serve("t2_1", 1, 0);
    serve("t2_2", 2, 2);
    serve("t2_3", 3, 1);
    tick;

    do_reset;
    set_word(0, 16'h0bb0);
    set_word(1, 16'hb00b);
    req = 4'b0011;
    rdy = 1'b0;
    wait_gnt("t3");
    check("t3_gnt", 32'(gnt), 1);
    tick;
    req[0] = 1'b0;
    wait_valid("t3");
    check("t3_data", 32'(res), 2);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t3_hold", {valid, gnt, id, res},
            {1'b1, 4'b0000, 2'd0, 3'd2});
    end
    rdy = 1'b1;
    tick;
    check("t3_next_gnt", 32'(gnt), 2);
    check("t3_drop_valid", 32'(valid), 0);
    tick;
    req[1] = 1'b0;
    wait_valid("t3b");
    check("t3b_id", 32'(id), 1);
    check("t3b_data", 32'(res), 2);
    tick;

    do_reset;
    set_word(0, 16'hbbbb);
    set_word(2, 16'h00b0);
    set_word(3, 16'hbb00);
    req = 4'b0001;
    tick;
    check("t4_gnt", 32'(gnt), 1);
    rst = 1'b1;
    req = '0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t4_no_valid", 32'(valid), 0);
    end
    req = 4'b0100;
    serve("t4a", 2, 1);
    req = 4'b1001;
    serve("t4b", 3, 2);
    serve("t4c", 0, 4);
    tick;

    do_reset;
    set_word(3, 16'hb0b0);
    set_word(0, 16'h000b);
    req = 4'b1000;
    serve("t5a", 3, 2);
    req = 4'b1001;
    serve("t5b", 0, 1);
    serve("t5c", 3, 2);
    tick;

`ifdef MATCH_CFG_EN
    do_reset;
    cfg_we  = 1'b1;
    cfg_nib = 4'h2;
    tick;
    cfg_we = 1'b0;
    set_word(1, 16'h3422);
    req = 4'b0010;
    serve("t6a", 1, ref_count(16'h3422, 4'h2));
    tick;
    do_reset;
    set_word(1, 16'h3422);
    req = 4'b0010;
    serve("t6b", 1, ref_count(16'h3422, 4'hB));
    tick;
`endif

    do_reset;
    rr   = 0;
    drop = -1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      req_pre   = req;
      data_pre  = data;
      rdy_pre   = rdy;
      valid_pre = valid;
      id_pre    = id;
      res_pre   = res;
      if (valid && rdy) begin
        if (expq.size() == 0) begin
          check("rand_spurious_valid", 32'(valid), 0);
        end else begin
          e = expq.pop_front();
          check("rand_id", 32'(id), e.id);
          check("rand_data", 32'(res), e.res);
        end
      end
      tick;
      if (valid_pre && !rdy_pre)
        check("rand_hold", {valid, id, res},
              {1'b1, id_pre, res_pre});
      if (drop >= 0) begin
        req[drop] = 1'b0;
        drop = -1;
      end
      if (gnt != '0) begin
        win = ref_winner(req_pre, rr);
        check("rand_gnt", 32'(gnt), (win < 0) ? 0 : 32'(1 << win));
        if (win >= 0) begin
          e.id  = win;
          e.res = ref_count(data_pre[16*win +: 16], 4'hB);
          expq.push_back(e);
          rr   = (win + 1) % N;
          drop = win;
        end
      end
      if (cyc < 600) begin
        rdy = ($urandom_range(3) != 0);
        for (int k = 0; k < N; k++) begin
          if (!req[k] && k != drop && $urandom_range(2) == 0) begin
            for (int n = 0; n < 4; n++)
              w[4*n +: 4] = $urandom_range(1) ? 4'hB : 4'($urandom);
            set_word(k, w);
            req[k] = 1'b1;
          end
        end
      end else begin
        rdy = 1'b1;
      end
    end
    check("rand_drain_q", expq.size(), 0);
    check("rand_drain_req", 32'(req), 0);
    check("rand_drain_valid", 32'(valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
